// File: rtl/calc_pkg.sv
// Shared definitions for the calculator serial link: receiver states, frame geometry, field offsets.
// The TX side uses the same offsets, so a frame layout change only needs editing here.
package calc_pkg;

  localparam int SBITS_DEF       = 4;
  localparam int INBITS_DEF      = 8;
  localparam int HDR_BITS        = 8;
  localparam int FRAME_BITS_DEF  = HDR_BITS + 3 * INBITS_DEF;
  localparam int NBEATS          = FRAME_BITS_DEF / SBITS_DEF;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_e;

  function automatic int beats_of(input int frame_bits, input int sbits);
    return frame_bits / sbits;
  endfunction

  // LSB of operand/result field idx (0 = A) sitting below the header.
  function automatic int field_lsb(input int frame_bits, input int inbits, input int idx);
    return frame_bits - HDR_BITS - (idx + 1) * inbits;
  endfunction

  localparam int HDR_LSB = FRAME_BITS_DEF - HDR_BITS;
  localparam int FA_LSB  = field_lsb(FRAME_BITS_DEF, INBITS_DEF, 0);
  localparam int FB_LSB  = field_lsb(FRAME_BITS_DEF, INBITS_DEF, 1);
  localparam int FC_LSB  = field_lsb(FRAME_BITS_DEF, INBITS_DEF, 2);

endpackage

// File: rtl/calc_serial_rx_if.sv
// Serial link (ClkTx/DoutValid/DataOut) plus the reassembled-frame outputs.
// master = transmitter/consumer side, slave = the receiver.
interface calc_serial_rx_if
  import calc_pkg::*;
#(
  parameter int SBITS      = SBITS_DEF,
  parameter int INBITS     = INBITS_DEF,
  parameter int FRAME_BITS = HDR_BITS + 3 * INBITS
);

  logic                  ClkTx;
  logic                  DoutValid;
  logic [SBITS-1:0]      DataOut;
  logic [FRAME_BITS-1:0] FrameData;
  logic [HDR_BITS-1:0]   FrameHdr;
  logic [INBITS-1:0]     FieldA;
  logic [INBITS-1:0]     FieldB;
  logic [INBITS-1:0]     FieldC;
  logic                  FrameValid;
  logic                  FrameErr;
  logic                  RxBusy;

  modport master (
    output ClkTx, DoutValid, DataOut,
    input  FrameData, FrameHdr, FieldA, FieldB, FieldC, FrameValid, FrameErr, RxBusy
  );

  modport slave (
    input  ClkTx, DoutValid, DataOut,
    output FrameData, FrameHdr, FieldA, FieldB, FieldC, FrameValid, FrameErr, RxBusy
  );

endinterface

// File: rtl/calc_edge_det.sv
// Rising-edge detector for a signal already synchronous to Clk (e.g. the divided ClkTx).
module calc_edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/calc_serial_rx.sv
// Receiver for the calculator serial output: reassembles SBITS beats into one MSB-first frame.
// Optional RX_TIMEOUT_EN aborts a frame when ClkTx stalls while DoutValid stays high.
//
// state | meaning
// IDLE  | waiting for first beat (ClkTx rise with DoutValid)
// RECV  | collecting beats; leaves when DoutValid falls (or on timeout)
// DONE  | one cycle, frame presented; may accept the first beat of the next frame
module calc_serial_rx
  import calc_pkg::*;
#(
  parameter int SBITS      = SBITS_DEF,
  parameter int INBITS     = INBITS_DEF,
  parameter int FRAME_BITS = HDR_BITS + 3 * INBITS
`ifdef RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input logic            Clk,
  input logic            Reset,
  calc_serial_rx_if.slave rx
);

  localparam int NB = beats_of(FRAME_BITS, SBITS);
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] NB_C = CW'(NB);
  localparam int LSB_A = field_lsb(FRAME_BITS, INBITS, 0);
  localparam int LSB_B = field_lsb(FRAME_BITS, INBITS, 1);
  localparam int LSB_C = field_lsb(FRAME_BITS, INBITS, 2);

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic                  ovf_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  busy_q;

  logic rise;
  logic beat;
  logic shift_en;
  logic ovf_set;
  logic frame_end;
  logic abort;
  logic tmo_hit;
  logic arm_ok;

  calc_edge_det u_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (rx.ClkTx),
    .rise  (rise)
  );

  assign beat = rise & rx.DoutValid;

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    ovf_set   = 1'b0;
    frame_end = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat && arm_ok) begin
          shift_en = 1'b1;
          state_d  = RECV;
        end
      end
      RECV: begin
        if (!rx.DoutValid) begin
          frame_end = 1'b1;
          state_d   = DONE;
        end else if (beat) begin
          if (cnt_q < NB_C) shift_en = 1'b1;
          else              ovf_set  = 1'b1;
        end else if (tmo_hit) begin
          frame_end = 1'b1;
          abort     = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (beat && arm_ok) begin
          shift_en = 1'b1;
          state_d  = RECV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      shreg_q <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RECV);
      valid_q <= frame_end;
      err_q   <= frame_end & ((cnt_q != NB_C) | ovf_q | abort);
      if (frame_end) begin
        // Short frames are pushed up so the header stays in the top bits.
        frame_q <= shreg_q << (SBITS * int'(NB_C - cnt_q));
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else if (shift_en) begin
        shreg_q <= {shreg_q[FRAME_BITS-SBITS-1:0], rx.DataOut};
        cnt_q   <= (state_q == RECV) ? cnt_q + 1'b1 : CW'(1);
      end else if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_q;
  logic          guard_q;

  assign tmo_hit = (tmo_q == '0);
  assign arm_ok  = ~guard_q;

  // Guard keeps a stalled transmitter's late beats from opening a bogus frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tmo_q   <= TW'(TIMEOUT_CYC);
      guard_q <= 1'b0;
    end else begin
      if (shift_en || (state_q == RECV && beat)) tmo_q <= TW'(TIMEOUT_CYC);
      else if (state_q == RECV && tmo_q != '0)   tmo_q <= tmo_q - 1'b1;
      if (abort)              guard_q <= 1'b1;
      else if (!rx.DoutValid) guard_q <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign arm_ok  = 1'b1;
`endif

  assign rx.FrameData  = frame_q;
  assign rx.FrameHdr   = frame_q[FRAME_BITS-1 -: HDR_BITS];
  assign rx.FieldA     = frame_q[LSB_A +: INBITS];
  assign rx.FieldB     = frame_q[LSB_B +: INBITS];
  assign rx.FieldC     = frame_q[LSB_C +: INBITS];
  assign rx.FrameValid = valid_q;
  assign rx.FrameErr   = err_q;
  assign rx.RxBusy     = busy_q;

endmodule

// File: tb/tb_calc_serial_rx.sv
// Directed bench for calc_serial_rx (default build): beat-list frame model plus literal checks.
module tb_calc_serial_rx;

  localparam int NB = 8;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;

  calc_serial_rx_if bus ();

  calc_serial_rx dut (
    .Clk   (Clk),
    .Reset (Reset),
    .rx    (bus)
  );

  always #5 Clk = ~Clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   pulses = 0;
  logic last_err = 1'b0;
  logic [3:0] mq[$];
  exp_t exp_q[$];
  exp_t cur;

  always @(posedge Clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.FrameValid) begin
        pulses++;
        last_err = bus.FrameErr;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(bus.FrameValid), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("frame_data", bus.FrameData, cur.data);
          chk("frame_hdr", 32'(bus.FrameHdr), 32'(cur.data[31:24]));
          chk("field_a", 32'(bus.FieldA), 32'(cur.data[23:16]));
          chk("field_b", 32'(bus.FieldB), 32'(cur.data[15:8]));
          chk("field_c", 32'(bus.FieldC), 32'(cur.data[7:0]));
          chk("frame_err", 32'(bus.FrameErr), 32'(cur.err));
          chk("valid_cycle", 32'(cyc), 32'(cur.cyc));
        end
      end else begin
        chk("err_without_valid", 32'(bus.FrameErr), 32'd0);
      end
    end
  end

  // Beats are packed MSB-first into 'beats'; one ClkTx rise every 3 Clk.
  task automatic send(input logic [63:0] beats, input int n);
    for (int i = 0; i < n; i++) begin
      bus.DoutValid = 1'b1;
      bus.DataOut   = beats[63-4*i -: 4];
      bus.ClkTx     = 1'b1;
      mq.push_back(bus.DataOut);
      @(negedge Clk);
      bus.ClkTx = 1'b0;
      repeat (2) @(negedge Clk);
    end
  endtask

  task automatic end_frame(input int gap);
    exp_t e;
    e.data = 32'd0;
    for (int i = 0; i < mq.size() && i < NB; i++)
      e.data |= 32'(mq[i]) << (28 - 4 * i);
    e.err = (mq.size() != NB);
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    mq.delete();
    bus.DoutValid = 1'b0;
    bus.DataOut   = 4'h0;
    repeat (gap) @(negedge Clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    @(negedge Clk);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    bus.ClkTx = 1'b0;
    bus.DoutValid = 1'b0;
    bus.DataOut = 4'h0;
    repeat (2) @(negedge Clk);
    chk("reset_data", bus.FrameData, 32'd0);
    chk("reset_valid", 32'(bus.FrameValid), 32'd0);
    chk("reset_err", 32'(bus.FrameErr), 32'd0);
    chk("reset_busy", 32'(bus.RxBusy), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    send(64'h1234_5678_0000_0000, 8);
    chk("nominal_busy", 32'(bus.RxBusy), 32'd1);
    end_frame(3);
    drain("nominal_drain");
    chk("nominal_lit_data", bus.FrameData, 32'h12345678);
    chk("nominal_lit_hdr", 32'(bus.FrameHdr), 32'h12);
    chk("nominal_lit_fa", 32'(bus.FieldA), 32'h34);
    chk("nominal_lit_fb", 32'(bus.FieldB), 32'h56);
    chk("nominal_lit_fc", 32'(bus.FieldC), 32'h78);
    chk("nominal_lit_err", 32'(last_err), 32'd0);
    chk("nominal_idle_busy", 32'(bus.RxBusy), 32'd0);

    send(64'hABCD_E000_0000_0000, 5);
    end_frame(3);
    drain("short_drain");
    chk("short_lit_data", bus.FrameData, 32'hABCDE000);
    chk("short_lit_err", 32'(last_err), 32'd1);

    send(64'h1234_5678_9A00_0000, 10);
    end_frame(3);
    drain("ovf_drain");
    chk("ovf_lit_data", bus.FrameData, 32'h12345678);
    chk("ovf_lit_err", 32'(last_err), 32'd1);

    send(64'hCAFE_F00D_0000_0000, 8);
    end_frame(1);
    send(64'h0BAD_BEEF_0000_0000, 8);
    end_frame(3);
    drain("b2b_drain");
    chk("b2b_lit_data", bus.FrameData, 32'h0BADBEEF);
    chk("b2b_lit_err", 32'(last_err), 32'd0);

    // DoutValid alone, no ClkTx rise: must not open a frame.
    bus.DoutValid = 1'b1;
    repeat (5) @(negedge Clk);
    bus.DoutValid = 1'b0;
    repeat (3) @(negedge Clk);
    chk("norise_busy", 32'(bus.RxBusy), 32'd0);
    chk("norise_data", bus.FrameData, 32'h0BADBEEF);

    send(64'h9870_0000_0000_0000, 3);
    mq.delete();
    Reset = 1'b1;
    bus.DoutValid = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("midreset_busy", 32'(bus.RxBusy), 32'd0);
    chk("midreset_data", bus.FrameData, 32'd0);
    repeat (4) @(negedge Clk);

    send(64'h1122_3344_0000_0000, 8);
    end_frame(3);
    drain("after_reset_drain");
    chk("after_reset_lit_data", bus.FrameData, 32'h11223344);
    chk("after_reset_lit_err", 32'(last_err), 32'd0);

    repeat (5) @(negedge Clk);
    chk("pulse_count", 32'(pulses), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
